// File: rtl/prog_loader.sv
// Byte-stream program loader: packs synchronized bytes into little-endian words and writes program memory.
// Optional byte checksum on chk is built when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              byte_stb,
   input  logic [7:0]        byte_in,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              load_done,
   output logic              ovf,
   output logic              partial,
   output logic [7:0]        chk
);

   // word_addr must be able to hold DEPTH itself so it can saturate there
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_LOAD,
      S_WRITE
   } state_e;

   state_e              state_q;
   logic                load_en_meta_q, load_en_s_q;
   logic                stb_meta_q, stb_s_q, stb_s_dly_q;
   logic [1:0]          byte_idx_q, byte_idx_d;
   logic [CNT_W-1:0]    word_addr_q;
   logic [31:0]         asm_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic                cpu_run_q, load_done_q, ovf_q, partial_q;
   logic                stb_edge, load_entry, capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_en_meta_q <= 1'b0;
         load_en_s_q    <= 1'b0;
         stb_meta_q     <= 1'b0;
         stb_s_q        <= 1'b0;
         stb_s_dly_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the pre-edge
         // value, which is what turns these lines into a real shift chain.
         load_en_meta_q <= load_en;
         load_en_s_q    <= load_en_meta_q;
         stb_meta_q     <= byte_stb;
         stb_s_q        <= stb_meta_q;
         stb_s_dly_q    <= stb_s_q;
      end
   end

   always_comb begin
      // NOTE: every signal gets a value on every path through this block, so
      // no latch is inferred.
      stb_edge   = stb_s_q & ~stb_s_dly_q;
      byte_idx_d = byte_idx_q + 2'd1;
      load_entry = ((state_q == S_IDLE) || (state_q == S_RUN)) && load_en_s_q;
      capture    = (state_q == S_LOAD) && stb_edge;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         byte_idx_q  <= 2'd0;
         word_addr_q <= '0;
         asm_q       <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         cpu_run_q   <= 1'b0;
         load_done_q <= 1'b0;
         ovf_q       <= 1'b0;
         partial_q   <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_RUN: begin
               if (load_entry) begin
                  state_q     <= S_LOAD;
                  cpu_run_q   <= 1'b0;
                  byte_idx_q  <= 2'd0;
                  word_addr_q <= '0;
                  load_done_q <= 1'b0;
                  ovf_q       <= 1'b0;
                  partial_q   <= 1'b0;
               end else begin
                  state_q   <= S_RUN;
                  cpu_run_q <= 1'b1;
               end
            end
            S_LOAD: begin
               if (capture) begin
                  asm_q[{byte_idx_q, 3'b000} +: 8] <= byte_in;
                  byte_idx_q                       <= byte_idx_d;
               end
               // A completed word is always written; a pending exit is then
               // taken on the next LOAD cycle with byte_idx already back at 0.
               if (capture && (byte_idx_q == 2'd3)) begin
                  state_q <= S_WRITE;
               end else if (!load_en_s_q) begin
                  if ((capture ? byte_idx_d : byte_idx_q) != 2'd0) begin
                     partial_q <= 1'b1;
                  end
                  byte_idx_q  <= 2'd0;
                  load_done_q <= 1'b1;
                  cpu_run_q   <= 1'b1;
                  state_q     <= S_RUN;
               end
            end
            S_WRITE: begin
               if (word_addr_q < DEPTH_C) begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= ADDR_W'(word_addr_q);
                  mem_wdata_q <= asm_q;
                  word_addr_q <= word_addr_q + CNT_W'(1);
               end else begin
                  ovf_q <= 1'b1;
               end
               state_q <= S_LOAD;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] chk_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q <= 8'd0;
      end else if (load_entry) begin
         chk_q <= 8'd0;
      end else if (capture) begin
         chk_q <= chk_q ^ byte_in;
      end
   end

   assign chk = chk_q;
`else
   assign chk = 8'd0;
`endif

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_run   = cpu_run_q;
   assign load_done = load_done_q;
   assign ovf       = ovf_q;
   assign partial   = partial_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte tables for word packing plus hand sequences
// for partial exit, overflow and mid-load reset.
module tb_prog_loader;

   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;
`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_en;
   logic              byte_stb;
   logic [7:0]        byte_in;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_run;
   logic              load_done;
   logic              ovf;
   logic              partial;
   logic [7:0]        chk;

   int total = 0;
   int bad   = 0;

   logic [31:0] wr_data[$];
   logic [31:0] wr_addr[$];
   int          wide_cnt = 0;
   logic        we_prev  = 1'b0;

   typedef struct {
      logic [7:0]  data;
      int          exp_n;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[12];

   prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (load_en),
      .byte_stb  (byte_stb),
      .byte_in   (byte_in),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_run   (cpu_run),
      .load_done (load_done),
      .ovf       (ovf),
      .partial   (partial),
      .chk       (chk)
   );

   always #5 clk = ~clk;

   // Write monitor: logs every pulse and counts pulses longer than one cycle
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(32'(mem_addr));
         wr_data.push_back(mem_wdata);
         if (we_prev) wide_cnt++;
      end
      we_prev = (mem_we === 1'b1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      wr_data.delete();
      wr_addr.delete();
      wide_cnt = 0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      byte_in  = d;
      byte_stb = 1'b1;
      tick(2);
      byte_stb = 1'b0;
      tick(4);
   endtask

   task automatic enter_load();
      load_en = 1'b1;
      tick(5);
      clear_log();
   endtask

   task automatic exit_load();
      load_en = 1'b0;
      tick(5);
   endtask

   task automatic apply_vec(input int i);
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_writes", i), 32'(wr_data.size()), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0 && wr_data.size() == vecs[i].exp_n) begin
         check($sformatf("vec%0d_addr", i), wr_addr[vecs[i].exp_n-1], vecs[i].exp_addr);
         check($sformatf("vec%0d_wdata", i), wr_data[vecs[i].exp_n-1], vecs[i].exp_wdata);
      end
   endtask

   function automatic logic [7:0] ovf_byte(input int i);
      return 8'((i * 7 + 3) & 8'hff);
   endfunction

   initial begin
      logic [31:0] w;
      int          mism;

      // Session A: one instruction word; session B: two words
      vecs[0]  = '{8'h13, 0, 32'd0, 32'h0};
      vecs[1]  = '{8'h05, 0, 32'd0, 32'h0};
      vecs[2]  = '{8'h10, 0, 32'd0, 32'h0};
      vecs[3]  = '{8'h00, 1, 32'd0, 32'h00100513};
      vecs[4]  = '{8'h01, 0, 32'd0, 32'h0};
      vecs[5]  = '{8'h02, 0, 32'd0, 32'h0};
      vecs[6]  = '{8'h03, 0, 32'd0, 32'h0};
      vecs[7]  = '{8'h04, 1, 32'd0, 32'h04030201};
      vecs[8]  = '{8'h05, 1, 32'd0, 32'h04030201};
      vecs[9]  = '{8'h06, 1, 32'd0, 32'h04030201};
      vecs[10] = '{8'h07, 1, 32'd0, 32'h04030201};
      vecs[11] = '{8'h08, 2, 32'd1, 32'h08070605};

      rst_n    = 1'b0;
      load_en  = 1'b0;
      byte_stb = 1'b0;
      byte_in  = 8'h00;
      #22;
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_cpu_run", 32'(cpu_run), 32'd0);
      check("rst_flags", {29'd0, load_done, ovf, partial}, 32'd0);
      check("rst_chk", 32'(chk), 32'd0);

      @(negedge clk);
      rst_n = 1'b1;
      tick(4);
      check("boot_cpu_run", 32'(cpu_run), 32'd1);
      check("boot_no_write", 32'(wr_data.size()), 32'd0);

      // Session A
      enter_load();
      check("load_cpu_held", 32'(cpu_run), 32'd0);
      for (int i = 0; i < 4; i++) apply_vec(i);
      exit_load();
      check("a_load_done", 32'(load_done), 32'd1);
      check("a_partial", 32'(partial), 32'd0);
      check("a_cpu_run", 32'(cpu_run), 32'd1);
      check("a_chk", 32'(chk), CHK_ON ? 32'h06 : 32'h00);

      // Session B
      enter_load();
      check("b_load_done_cleared", 32'(load_done), 32'd0);
      for (int i = 4; i < 12; i++) apply_vec(i);
      exit_load();
      check("b_pulse_width", 32'(wide_cnt), 32'd0);
      check("b_chk", 32'(chk), CHK_ON ? 32'h08 : 32'h00);

      // Six bytes, then exit: second word is partial and discarded
      enter_load();
      for (int i = 0; i < 6; i++) send_byte(8'(8'h21 + i));
      exit_load();
      check("p_writes", 32'(wr_data.size()), 32'd1);
      check("p_wdata_held", mem_wdata, 32'h24232221);
      check("p_addr_held", 32'(mem_addr), 32'd0);
      check("p_partial", 32'(partial), 32'd1);
      check("p_load_done", 32'(load_done), 32'd1);

      // 33 words into a 32-word memory
      enter_load();
      check("o_partial_cleared", 32'(partial), 32'd0);
      for (int i = 0; i < 4 * DEPTH; i++) send_byte(ovf_byte(i));
      check("o_writes_full", 32'(wr_data.size()), 32'(DEPTH));
      check("o_ovf_before", 32'(ovf), 32'd0);
      for (int i = 4 * DEPTH; i < 4 * DEPTH + 4; i++) send_byte(ovf_byte(i));
      check("o_writes_after", 32'(wr_data.size()), 32'(DEPTH));
      check("o_ovf_after", 32'(ovf), 32'd1);
      check("o_addr_stays", 32'(mem_addr), 32'(DEPTH - 1));
      mism = 0;
      for (int k = 0; k < wr_data.size(); k++) begin
         w = {ovf_byte(4*k+3), ovf_byte(4*k+2), ovf_byte(4*k+1), ovf_byte(4*k)};
         if (wr_data[k] !== w || wr_addr[k] !== 32'(k)) mism++;
      end
      check("o_word_mismatches", 32'(mism), 32'd0);
      check("o_pulse_width", 32'(wide_cnt), 32'd0);

      // Asynchronous reset after two bytes of a word
      send_byte(8'h55);
      send_byte(8'h66);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_mem_addr", 32'(mem_addr), 32'd0);
      check("ar_mem_wdata", mem_wdata, 32'd0);
      check("ar_flags", {28'd0, cpu_run, load_done, ovf, partial}, 32'd0);
      check("ar_chk", 32'(chk), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(6);
      clear_log();
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      send_byte(8'hDD);
      check("ar_writes", 32'(wr_data.size()), 32'd1);
      if (wr_data.size() == 1) begin
         check("ar_reload_wdata", wr_data[0], 32'hDDCCBBAA);
         check("ar_reload_addr", wr_addr[0], 32'd0);
      end
      exit_load();
      check("ar_chk_final", 32'(chk), CHK_ON ? 32'h00 : 32'h00);
      check("ar_cpu_run", 32'(cpu_run), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
